// File: rtl/pc_sequencer.sv
// Fetch/branch sequencer that drives the Program_Counter select (PS) and operand (PC_IN).
// Optional fetch-timeout watchdog is enabled by defining PC_SEQ_TIMEOUT_EN.
module pc_sequencer #(
   parameter int AW      = 64,
   parameter int OFFW    = 26,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            imem_ack,
   input  logic            br_uncond,
   input  logic            br_cond,
   input  logic            zero_flag,
   input  logic            br_reg,
   input  logic [OFFW-1:0] br_imm,
   input  logic [AW-1:0]   reg_target,
   input  logic            halt,
   input  logic            stall,
   output logic            imem_req,
   output logic            ir_load,
   output logic [1:0]      PS,
   output logic [AW-1:0]   PC_IN,
   output logic            halted,
   output logic            fault
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] DECODE = 3'd2;
   localparam logic [2:0] UPDATE = 3'd3;
   localparam logic [2:0] HALTED = 3'd4;

   localparam logic [1:0] PS_HOLD = 2'b00;
   localparam logic [1:0] PS_INC  = 2'b01;
   localparam logic [1:0] PS_LOAD = 2'b10;
   localparam logic [1:0] PS_REL  = 2'b11;

   logic [2:0]    state, state_nxt;
   logic [1:0]    dec_ps;
   logic [AW-1:0] dec_pc_in;
   logic          dec_halt;
   logic [AW-1:0] br_off;
   logic          fetch_timeout;

   // Word offset from the decoder becomes a sign-extended byte offset.
   assign br_off = {{(AW-OFFW){br_imm[OFFW-1]}}, br_imm} << 2;

`ifdef PC_SEQ_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
   logic [7:0] wait_cnt;
   logic       fault_q;

   // The ack is checked first in FETCH, so an ack on the last allowed cycle wins.
   assign fetch_timeout = (state == FETCH) && !imem_ack && (wait_cnt == TIMEOUT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= '0;
         fault_q  <= 1'b0;
      end else begin
         if (state != FETCH)  wait_cnt <= '0;
         else if (!imem_ack)  wait_cnt <= wait_cnt + 8'd1;
         if (fetch_timeout)   fault_q  <= 1'b1;
      end
   end

   assign fault = fault_q;
`else
   assign fetch_timeout = 1'b0;
   assign fault         = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   if (imem_ack)          state_nxt = DECODE;
                  else if (fetch_timeout) state_nxt = HALTED;
         DECODE:  state_nxt = UPDATE;
         UPDATE:  if (!stall) state_nxt = dec_halt ? HALTED : FETCH;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         dec_ps    <= PS_HOLD;
         dec_pc_in <= '0;
         dec_halt  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == DECODE) begin
            dec_halt <= halt;
            if (halt) begin
               dec_ps    <= PS_HOLD;
               dec_pc_in <= '0;
            end else if (br_reg) begin
               dec_ps    <= PS_LOAD;
               dec_pc_in <= reg_target;
            end else if (br_uncond || (br_cond && zero_flag)) begin
               dec_ps    <= PS_REL;
               dec_pc_in <= br_off;
            end else begin
               dec_ps    <= PS_INC;
               dec_pc_in <= '0;
            end
         end
      end
   end

   // Outputs decode straight from state so an async reset zeroes them at once.
   assign imem_req = (state == FETCH);
   assign ir_load  = (state == FETCH) && imem_ack;
   assign halted   = (state == HALTED);
   assign PS       = (state == UPDATE && !stall) ? dec_ps : PS_HOLD;
   assign PC_IN    = (state == UPDATE) ? dec_pc_in : '0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default build and PC_SEQ_TIMEOUT_EN build).
module tb_pc_sequencer;
   localparam int AW   = 64;
   localparam int OFFW = 26;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            imem_ack = 1'b0;
   logic            br_uncond = 1'b0, br_cond = 1'b0, zero_flag = 1'b0, br_reg = 1'b0;
   logic [OFFW-1:0] br_imm = '0;
   logic [AW-1:0]   reg_target = '0;
   logic            halt = 1'b0, stall = 1'b0;
   logic            imem_req, ir_load, halted, fault;
   logic [1:0]      PS;
   logic [AW-1:0]   PC_IN;

   int errors = 0;
   int checks = 0;

   pc_sequencer #(.AW(AW), .OFFW(OFFW), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .imem_ack(imem_ack), .br_uncond(br_uncond), .br_cond(br_cond),
      .zero_flag(zero_flag), .br_reg(br_reg), .br_imm(br_imm), .reg_target(reg_target),
      .halt(halt), .stall(stall), .imem_req(imem_req), .ir_load(ir_load), .PS(PS),
      .PC_IN(PC_IN), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   // Stimulus only: entered at a negedge in FETCH, returns at the negedge of UPDATE.
   task automatic run_instr(input logic ub, input logic cb, input logic zf, input logic rb,
                            input logic [OFFW-1:0] imm, input logic [AW-1:0] tgt, input logic h);
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      br_uncond = ub; br_cond = cb; zero_flag = zf; br_reg = rb;
      br_imm = imm; reg_target = tgt; halt = h;
      @(negedge clk);
      br_uncond = 0; br_cond = 0; zero_flag = 0; br_reg = 0; br_imm = '0; reg_target = '0; halt = 0;
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if ({PS, PC_IN, imem_req, ir_load, halted, fault} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: PS=%b PC_IN=%h req=%b irl=%b halted=%b fault=%b, all must be 0",
                  PS, PC_IN, imem_req, ir_load, halted, fault);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL idle_req: imem_req=%b want 0", imem_req);
      end
      @(negedge clk);
      imem_ack = 1'b1;
      #1;
      checks++;
      if ({imem_req, ir_load, PS} !== 4'b1100) begin
         errors++; $display("FAIL fetch_first: req/irl/PS=%b want 1100", {imem_req, ir_load, PS});
      end
      @(negedge clk);
      imem_ack = 1'b0;
      #1;
      checks++;
      if ({imem_req, ir_load, PS} !== 4'b0000) begin
         errors++; $display("FAIL decode_outs: req/irl/PS=%b want 0000", {imem_req, ir_load, PS});
      end
      @(negedge clk);
      #1;
      checks++;
      if (PS !== 2'b01 || PC_IN !== 64'd0) begin
         errors++; $display("FAIL seq_update: PS=%b PC_IN=%h want 01/0", PS, PC_IN);
      end
      @(negedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b1 || PS !== 2'b00) begin
         errors++; $display("FAIL refetch: req=%b PS=%b want 1/00", imem_req, PS);
      end
   endtask

   task automatic test_branches;
      run_instr(1, 0, 0, 0, 26'd8, '0, 0);
      imem_ack = 1'b1;
      #1;
      checks++;
      if (PS !== 2'b11 || PC_IN !== 64'd32) begin
         errors++; $display("FAIL b_plus8: PS=%b PC_IN=%h want 11/20", PS, PC_IN);
      end
      checks++;
      if (ir_load !== 1'b0) begin
         errors++; $display("FAIL ack_in_update: ir_load=%b want 0", ir_load);
      end
      imem_ack = 1'b0;
      @(negedge clk);
      run_instr(1, 0, 0, 0, -26'sd4, '0, 0);
      #1;
      checks++;
      if (PS !== 2'b11 || PC_IN !== 64'hFFFF_FFFF_FFFF_FFF0) begin
         errors++; $display("FAIL b_minus4: PS=%b PC_IN=%h want 11/fffffffffffffff0", PS, PC_IN);
      end
      @(negedge clk);
      run_instr(0, 1, 0, 0, 26'd4, '0, 0);
      #1;
      checks++;
      if (PS !== 2'b01 || PC_IN !== 64'd0) begin
         errors++; $display("FAIL cbz_not_taken: PS=%b PC_IN=%h want 01/0", PS, PC_IN);
      end
      @(negedge clk);
      run_instr(0, 1, 1, 0, 26'd4, '0, 0);
      #1;
      checks++;
      if (PS !== 2'b11 || PC_IN !== 64'd16) begin
         errors++; $display("FAIL cbz_taken: PS=%b PC_IN=%h want 11/10", PS, PC_IN);
      end
      @(negedge clk);
      run_instr(1, 0, 0, 1, 26'd8, 64'd4, 0);
      #1;
      checks++;
      if (PS !== 2'b10 || PC_IN !== 64'd4) begin
         errors++; $display("FAIL br_priority: PS=%b PC_IN=%h want 10/4", PS, PC_IN);
      end
      @(negedge clk);
   endtask

   task automatic test_stall;
      run_instr(1, 0, 0, 0, 26'd2, '0, 0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (PS !== 2'b00 || imem_req !== 1'b0) begin
            errors++; $display("FAIL stall_hold%0d: PS=%b req=%b want 00/0", i, PS, imem_req);
         end
         @(negedge clk);
      end
      stall = 1'b0;
      #1;
      checks++;
      if (PS !== 2'b11 || PC_IN !== 64'd8) begin
         errors++; $display("FAIL stall_release: PS=%b PC_IN=%h want 11/8", PS, PC_IN);
      end
      @(negedge clk);
      stall = 1'b1;
      imem_ack = 1'b1;
      #1;
      checks++;
      if (ir_load !== 1'b1 || PS !== 2'b00) begin
         errors++; $display("FAIL stall_in_fetch: irl=%b PS=%b want 1/00", ir_load, PS);
      end
      @(negedge clk);
      stall = 1'b0;
      imem_ack = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (PS !== 2'b01) begin
         errors++; $display("FAIL after_stall_seq: PS=%b want 01", PS);
      end
      @(negedge clk);
   endtask

   task automatic test_halt;
      run_instr(1, 0, 0, 0, 26'd8, '0, 1);
      #1;
      checks++;
      if (PS !== 2'b00 || halted !== 1'b0) begin
         errors++; $display("FAIL halt_update: PS=%b halted=%b want 00/0", PS, halted);
      end
      imem_ack = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({PS, halted, imem_req, ir_load} !== 5'b00100) begin
            errors++; $display("FAIL halted_c%0d: PS/halted/req/irl=%b want 00100", i,
                               {PS, halted, imem_req, ir_load});
         end
      end
      imem_ack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (halted !== 1'b0) begin
         errors++; $display("FAIL halt_reset: halted=%b want 0", halted);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if ({PS, PC_IN, imem_req, ir_load, halted} !== '0) begin
         errors++; $display("FAIL mid_fetch_reset: req=%b PS=%b PC_IN=%h halted=%b want all 0",
                            imem_req, PS, PC_IN, halted);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset: req=%b want 0", imem_req);
      end
      @(negedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b1) begin
         errors++; $display("FAIL fetch_after_reset: req=%b want 1", imem_req);
      end
   endtask

   task automatic test_timeout;
`ifdef PC_SEQ_TIMEOUT_EN
      // Entered at FETCH cycle 1 with ack low.
      for (int i = 0; i < 3; i++) @(negedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b1 || fault !== 1'b0) begin
         errors++; $display("FAIL to_fetch4: req=%b fault=%b want 1/0", imem_req, fault);
      end
      @(negedge clk);
      #1;
      checks++;
      if (halted !== 1'b1 || fault !== 1'b1 || imem_req !== 1'b0) begin
         errors++; $display("FAIL to_fault: halted=%b fault=%b req=%b want 1/1/0", halted, fault, imem_req);
      end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) @(negedge clk);
      imem_ack = 1'b1;
      #1;
      checks++;
      if (ir_load !== 1'b1) begin
         errors++; $display("FAIL to_late_ack: ir_load=%b want 1", ir_load);
      end
      @(negedge clk);
      imem_ack = 1'b0;
      #1;
      checks++;
      if (fault !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b0) begin
         errors++; $display("FAIL to_ack_wins: fault=%b halted=%b req=%b want 0/0/0", fault, halted, imem_req);
      end
`else
      for (int i = 0; i < 10; i++) @(negedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b1 || fault !== 1'b0 || halted !== 1'b0) begin
         errors++; $display("FAIL wait_forever: req=%b fault=%b halted=%b want 1/0/0", imem_req, fault, halted);
      end
`endif
   endtask

   initial begin
      test_reset;
      test_branches;
      test_stall;
      test_halt;
      test_timeout;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle fetch/branch controller that drives the select (PS) and operand (PC_IN) inputs of the Program_Counter.
- Handshakes with instruction memory, latches the instruction, takes branch decisions from the decoder and issues exactly one PC update per instruction.
- Sits between the decoder/ALU flags and Program_Counter in the top level.

Parameters:
- AW, 64, PC / address width; PC_IN width.
- OFFW, 26, width of signed branch word offset from decoder.
- TIMEOUT, 255, max fetch-wait cycles (used only with optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- imem_ack  in  1  instruction memory data valid this cycle.
- br_uncond  in  1  decoder: unconditional relative branch (B).
- br_cond  in  1  decoder: conditional branch (CBZ), taken if zero_flag.
- zero_flag  in  1  ALU zero flag.
- br_reg  in  1  decoder: register-indirect branch (BR).
- br_imm  in  OFFW  signed word offset.
- reg_target  in  AW  absolute target for br_reg.
- halt  in  1  decoder: halt instruction.
- stall  in  1  hold PC update.
- imem_req  out  1  fetch request.
- ir_load  out  1  instruction register load strobe.
- PS  out  2  PC select: 00 hold, 01 PC+4, 10 load PC_IN, 11 PC+PC_IN.
- PC_IN  out  AW  PC operand.
- halted  out  1  sequencer stopped.
- fault  out  1  fetch timeout (optional feature only).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; PS=00, PC_IN=0, imem_req=0, ir_load=0, halted=0, fault=0; decision registers cleared. Asserting rst mid-instruction aborts immediately; no partial PC update is issued.
- States: IDLE, FETCH, DECODE, UPDATE, HALTED.
- IDLE: one cycle after reset release, then FETCH.
- FETCH:
  - imem_req=1, PS=00.
  - ir_load = FETCH & imem_ack (combinational).
  - On imem_ack go to DECODE; otherwise stay.
- DECODE: one cycle; sample decoder inputs into registered decision with priority halt > br_reg > br_uncond > (br_cond & zero_flag) > sequential; go to UPDATE.
- Decision to PS/PC_IN:
  - halt: PS=00, then HALTED.
  - br_reg: PS=10, PC_IN=reg_target.
  - br_uncond, or br_cond taken: PS=11, PC_IN = sign_extend(br_imm, AW) << 2 (byte offset; negative offsets wrap modulo 2^AW).
  - br_cond with zero_flag=0, or no branch: PS=01, PC_IN=0.
- UPDATE:
  - Drive decided PS/PC_IN for exactly one cycle; PC updates at that edge; then FETCH.
  - If stall=1 in UPDATE: PS=00, stay in UPDATE, decision held.
  - stall has no effect in other states.
- HALTED: PS=00, halted=1, imem_req=0; only reset exits.
- Outside UPDATE, PS=00 and PC_IN=0 at all times.
- Minimum 3 cycles per instruction (ack in first FETCH cycle).
- imem_ack outside FETCH is ignored.

Optional Feature:
- Macro PC_SEQ_TIMEOUT_EN.
- Defined: 8-bit wait counter clears on entering FETCH and increments each FETCH cycle without imem_ack. When count reaches TIMEOUT without ack: go to HALTED with fault=1 (sticky until reset). An ack on the TIMEOUT-th cycle wins over the timeout.
- Undefined: FETCH waits indefinitely; fault tied to 0; no counter logic.

Test Plan:
- Reset release, ack on first FETCH cycle, no branch -> IDLE, FETCH (ir_load=1), DECODE, UPDATE with PS=01; sequence repeats every 3 cycles.
- br_uncond, br_imm=8 -> UPDATE cycle PS=11, PC_IN=32; br_imm=-4 -> PC_IN=0xFFFF_FFFF_FFFF_FFF0.
- br_cond=1, zero_flag=0 -> PS=01; zero_flag=1, br_imm=4 -> PS=11, PC_IN=16; br_reg=1 together with br_uncond=1, reg_target=4 -> PS=10, PC_IN=4 (priority).
- stall=1 for 3 cycles in UPDATE with PS=11 pending -> PS=00 for 3 cycles, then PS=11 once.
- halt=1 -> PS=00, halted=1, imem_req=0 persists 20 cycles; rst=0 pulse mid-FETCH -> outputs zero immediately, IDLE on release.
- With PC_SEQ_TIMEOUT_EN, TIMEOUT=4, imem_ack held 0 -> HALTED and fault=1 after 4 FETCH cycles; ack on 4th cycle -> DECODE, fault=0.
